// File: rtl/gn_mdl_clock_mon.sv
// gn_mdl_clock_mon
//   Receive-side frequency checker for a generated clock. mon_clk is sampled as
//   asynchronous data in the clk domain. Its rising edges are counted over fixed
//   windows of P_WINDOW clk cycles, and each completed window is graded against
//   [P_EXP_MIN, P_EXP_MAX]. A separate timeout flags a stopped clock.
//
//   Ports
//     clk        in   reference clock, all flops on rising edge
//     rst        in   asynchronous active-high reset
//     mon_clk    in   clock under test (async, must be slower than clk/2)
//     en         in   1 = measure back-to-back windows, 0 = idle
//     clr_err    in   single-cycle pulse that clears freq_err
//     meas_valid out  single-cycle pulse when meas_count/freq_ok update
//     meas_count out  edge count of the last completed window
//     freq_ok    out  last window count was inside the accepted range
//     freq_err   out  sticky out-of-range flag
//     clk_lost   out  no mon_clk edge for P_TIMEOUT clk cycles
module gn_mdl_clock_mon #(
    parameter int P_WINDOW  = 1000,
    parameter int P_EXP_MIN = 198,
    parameter int P_EXP_MAX = 202,
    parameter int P_TIMEOUT = 64,
    parameter int P_CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mon_clk,
    input  logic               en,
    input  logic               clr_err,
    output logic               meas_valid,
    output logic [P_CNT_W-1:0] meas_count,
    output logic               freq_ok,
    output logic               freq_err,
    output logic               clk_lost
);

    localparam int WC_W = (P_WINDOW > 1) ? $clog2(P_WINDOW) : 1;
    localparam int TC_W = $clog2(P_TIMEOUT + 1);

    localparam logic [WC_W-1:0]    WIN_LAST = WC_W'(P_WINDOW - 1);
    localparam logic [TC_W-1:0]    TMO      = TC_W'(P_TIMEOUT);
    localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]        EXP_MIN  = 32'(P_EXP_MIN);
    localparam logic [31:0]        EXP_MAX  = 32'(P_EXP_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISCARD,
        ST_MEASURE
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [P_CNT_W-1:0] ecnt_q, ecnt_d;
    logic [TC_W-1:0]    tcnt_q, tcnt_d;
    logic               meas_valid_q, meas_valid_d;
    logic [P_CNT_W-1:0] meas_count_q, meas_count_d;
    logic               freq_ok_q, freq_ok_d;
    logic               freq_err_q, freq_err_d;
    logic               clk_lost_q, clk_lost_d;

    logic               mon_edge;
    logic               active;
    logic               win_end;
    logic [P_CNT_W-1:0] ecnt_sum;
    logic               in_range;

    always_comb begin
        mon_edge = s2_q & ~s3_q;
        active   = en && (state_q != ST_IDLE);
        win_end  = active && (wcnt_q == WIN_LAST);
        // Count including this cycle's edge, saturating. On the window's last
        // cycle this is the final count, so an edge there lands in the ending window.
        ecnt_sum = (ecnt_q == CNT_MAX) ? CNT_MAX : ecnt_q + {{(P_CNT_W-1){1'b0}}, mon_edge};
        in_range = (32'(ecnt_sum) >= EXP_MIN) && (32'(ecnt_sum) <= EXP_MAX);

        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_DISCARD;
                ST_DISCARD: if (win_end) state_d = ST_MEASURE;
                default:    state_d = ST_MEASURE;
            endcase
        end

        // Window/edge counters only run while actively measuring; leaving
        // that (en low or idle) drops any partial window.
        wcnt_d = '0;
        ecnt_d = '0;
        if (active && !win_end) begin
            wcnt_d = wcnt_q + WC_W'(1);
            ecnt_d = ecnt_sum;
        end

        tcnt_d = '0;
        if (active && !mon_edge) begin
            tcnt_d = (tcnt_q == TMO) ? TMO : tcnt_q + TC_W'(1);
        end
        clk_lost_d = active && (tcnt_d == TMO);

        meas_valid_d = win_end && (state_q == ST_MEASURE);
        meas_count_d = meas_valid_d ? ecnt_sum : meas_count_q;

        freq_ok_d = freq_ok_q;
        if (!en)               freq_ok_d = 1'b0;
        else if (meas_valid_d) freq_ok_d = in_range;

        // A new out-of-range result outranks a simultaneous clear.
        freq_err_d = freq_err_q;
        if (meas_valid_d && !in_range) freq_err_d = 1'b1;
        else if (clr_err)              freq_err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            wcnt_q       <= '0;
            ecnt_q       <= '0;
            tcnt_q       <= '0;
            meas_valid_q <= 1'b0;
            meas_count_q <= '0;
            freq_ok_q    <= 1'b0;
            freq_err_q   <= 1'b0;
            clk_lost_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= mon_clk;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            wcnt_q       <= wcnt_d;
            ecnt_q       <= ecnt_d;
            tcnt_q       <= tcnt_d;
            meas_valid_q <= meas_valid_d;
            meas_count_q <= meas_count_d;
            freq_ok_q    <= freq_ok_d;
            freq_err_q   <= freq_err_d;
            clk_lost_q   <= clk_lost_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign meas_count = meas_count_q;
    assign freq_ok    = freq_ok_q;
    assign freq_err   = freq_err_q;
    assign clk_lost   = clk_lost_q;

endmodule

// File: tb/tb_gn_mdl_clock_mon.sv
`timescale 1ns/100ps
module tb_gn_mdl_clock_mon;

    logic        clk, rst;
    logic        mon_clk, en, clr_err;
    logic        meas_valid, freq_ok, freq_err, clk_lost;
    logic [15:0] meas_count;

    // second instance: narrow counter, short window, cycle-exact stimulus
    logic        m2, en2, clr_err2;
    logic        meas_valid2, freq_ok2, freq_err2, clk_lost2;
    logic [3:0]  meas_count2;

    int n_checks = 0;
    int n_fail   = 0;

    realtime mon_half = 20.0;
    bit      mon_run  = 1'b1;

    gn_mdl_clock_mon dut (
        .clk(clk), .rst(rst), .mon_clk(mon_clk), .en(en), .clr_err(clr_err),
        .meas_valid(meas_valid), .meas_count(meas_count), .freq_ok(freq_ok),
        .freq_err(freq_err), .clk_lost(clk_lost)
    );

    gn_mdl_clock_mon #(
        .P_WINDOW(100), .P_EXP_MIN(3), .P_EXP_MAX(5), .P_TIMEOUT(64), .P_CNT_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .mon_clk(m2), .en(en2), .clr_err(clr_err2),
        .meas_valid(meas_valid2), .meas_count(meas_count2), .freq_ok(freq_ok2),
        .freq_err(freq_err2), .clk_lost(clk_lost2)
    );

    // 125 MHz reference
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // clock under test; 0.3 ns offset keeps its edges off the clk edges
    initial begin
        mon_clk = 1'b0;
        #0.3;
        forever begin
            #(mon_half);
            if (mon_run) mon_clk = ~mon_clk;
            else         mon_clk = 1'b0;
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // waits (bounded) until meas_valid is seen at a falling edge
    task automatic wait_mv(input int maxc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!meas_valid && n < maxc);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr_err = 1'b0;
        en2 = 1'b0; clr_err2 = 1'b0; m2 = 1'b0;
        cyc(3);
        n_checks++;
        if ({meas_valid, meas_count, freq_ok, freq_err, clk_lost} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mv=%b cnt=%0d ok=%b err=%b lost=%b, want all 0",
                     meas_valid, meas_count, freq_ok, freq_err, clk_lost);
        end
        n_checks++;
        if ({meas_valid2, meas_count2, freq_ok2, freq_err2, clk_lost2} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs2: got mv=%b cnt=%0d ok=%b err=%b lost=%b, want all 0",
                     meas_valid2, meas_count2, freq_ok2, freq_err2, clk_lost2);
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_nominal();
        int n;
        en = 1'b1;
        wait_mv(2500, n);
        n_checks++;
        if (!meas_valid || n !== 2001) begin
            n_fail++;
            $display("FAIL first_valid_latency: got %0d cycles (mv=%b), want 2001", n, meas_valid);
        end
        n_checks++;
        if (meas_count < 199 || meas_count > 201) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d, want 199..201", meas_count);
        end
        n_checks++;
        if ({freq_ok, freq_err, clk_lost} !== 3'b100) begin
            n_fail++;
            $display("FAIL nominal_flags: got ok/err/lost=%b%b%b, want 100", freq_ok, freq_err, clk_lost);
        end
        cyc(1);
        n_checks++;
        if (meas_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse_width: got mv=%b one cycle later, want 0", meas_valid);
        end
        wait_mv(1100, n);
        n_checks++;
        if (!meas_valid || n !== 999) begin
            n_fail++;
            $display("FAIL window_period: got %0d more cycles (mv=%b), want 999", n, meas_valid);
        end
    endtask

    task automatic test_slow_clock();
        int n;
        mon_half = 25.0;
        wait_mv(1100, n);   // straddles the frequency change
        wait_mv(1100, n);
        n_checks++;
        if (!meas_valid || meas_count < 159 || meas_count > 161) begin
            n_fail++;
            $display("FAIL slow_count: got %0d (mv=%b), want 159..161", meas_count, meas_valid);
        end
        n_checks++;
        if ({freq_ok, freq_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL slow_flags: got ok/err=%b%b, want 01", freq_ok, freq_err);
        end
        mon_half = 20.0;
        wait_mv(1100, n);
        wait_mv(1100, n);
        n_checks++;
        if ({meas_valid, freq_ok, freq_err} !== 3'b111) begin
            n_fail++;
            $display("FAIL recover_sticky: got mv/ok/err=%b%b%b, want 111", meas_valid, freq_ok, freq_err);
        end
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        n_checks++;
        if (freq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_err: got freq_err=%b, want 0", freq_err);
        end
    endtask

    task automatic test_lost_clock();
        int n;
        cyc(300);
        mon_run = 1'b0;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!clk_lost && n < 100);
        n_checks++;
        if (!clk_lost || n < 55 || n > 75) begin
            n_fail++;
            $display("FAIL lost_timing: got %0d cycles after stop (lost=%b), want 55..75", n, clk_lost);
        end
        wait_mv(1100, n);
        n_checks++;
        if (!meas_valid || meas_count >= 200 || freq_err !== 1'b1 || freq_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_partial: got mv=%b cnt=%0d ok=%b err=%b, want cnt<200 ok=0 err=1",
                     meas_valid, meas_count, freq_ok, freq_err);
        end
        wait_mv(1100, n);
        n_checks++;
        if (!meas_valid || meas_count !== 16'd0 || clk_lost !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_empty_window: got mv=%b cnt=%0d lost=%b, want cnt=0 lost=1",
                     meas_valid, meas_count, clk_lost);
        end
        mon_run = 1'b1;
        @(posedge mon_clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_lost && n < 10);
        n_checks++;
        if (clk_lost !== 1'b0 || n > 4) begin
            n_fail++;
            $display("FAIL lost_recover: got lost=%b after %0d cycles, want 0 within 4", clk_lost, n);
        end
    endtask

    task automatic test_reset_midwindow();
        int n;
        wait_mv(1100, n);
        cyc(300);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({meas_valid, meas_count, freq_ok, freq_err, clk_lost} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_async: got mv=%b cnt=%0d ok=%b err=%b lost=%b, want all 0",
                     meas_valid, meas_count, freq_ok, freq_err, clk_lost);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_mv(2500, n);
        n_checks++;
        if (!meas_valid || n !== 2001) begin
            n_fail++;
            $display("FAIL rst_restart_latency: got %0d cycles (mv=%b), want 2001", n, meas_valid);
        end
        n_checks++;
        if (meas_count < 199 || meas_count > 201 || freq_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_restart_result: got cnt=%0d ok=%b, want 199..201 ok=1", meas_count, freq_ok);
        end
    endtask

    task automatic test_en_abort();
        int n;
        bit seen;
        logic [15:0] saved;
        cyc(300);
        saved = meas_count;
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (meas_valid) seen = 1'b1;
        end
        n_checks++;
        if ({seen, freq_ok, clk_lost} !== 3'b000 || meas_count !== saved) begin
            n_fail++;
            $display("FAIL en_low_state: got mv_seen=%b ok=%b lost=%b cnt=%0d, want 0 0 0 cnt=%0d",
                     seen, freq_ok, clk_lost, meas_count, saved);
        end
        en = 1'b1;
        wait_mv(2500, n);
        n_checks++;
        if (!meas_valid || n !== 2001) begin
            n_fail++;
            $display("FAIL reenable_latency: got %0d cycles (mv=%b), want 2001", n, meas_valid);
        end
        n_checks++;
        if (meas_count < 199 || meas_count > 201 || freq_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable_result: got cnt=%0d ok=%b, want 199..201 ok=1", meas_count, freq_ok);
        end
    endtask

    // p numbers the rising clk edges after en2 goes high; the DISCARD window
    // runs on edges 2..101, the first MEASURE window on 102..201, so its
    // result is visible after edge 201. A mon rise driven before edge q is
    // counted on edge q+2.
    task automatic test_saturate();
        bit early;
        early = 1'b0;
        en2 = 1'b1;
        for (int p = 1; p <= 201; p++) begin
            m2 = ((p % 5) < 2);
            clr_err2 = (p == 201);   // clear on the same cycle the error sets
            cyc(1);
            if (p < 201 && meas_valid2) early = 1'b1;
        end
        clr_err2 = 1'b0;
        n_checks++;
        if (early || meas_valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_valid_timing: got early=%b mv@201=%b, want 0 1", early, meas_valid2);
        end
        n_checks++;
        if (meas_count2 !== 4'd15 || freq_ok2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_count: got cnt=%0d ok=%b, want 15 0", meas_count2, freq_ok2);
        end
        n_checks++;
        if (freq_err2 !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: got freq_err=%b, want 1", freq_err2);
        end
        en2 = 1'b0;
        m2 = 1'b0;
        cyc(4);
    endtask

    task automatic test_window_boundary();
        int mv_cnt;
        mv_cnt = 0;
        en2 = 1'b1;
        for (int p = 1; p <= 301; p++) begin
            m2 = (p == 150 || p == 151 || p == 160 || p == 161 ||
                  p == 199 || p == 200 || p == 250 || p == 251);
            cyc(1);
            if (meas_valid2) mv_cnt++;
            if (p == 201) begin
                n_checks++;
                if (meas_valid2 !== 1'b1 || meas_count2 !== 4'd3 || freq_ok2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL boundary_win1: got mv=%b cnt=%0d ok=%b, want 1 3 1",
                             meas_valid2, meas_count2, freq_ok2);
                end
            end
            if (p == 301) begin
                n_checks++;
                if (meas_valid2 !== 1'b1 || meas_count2 !== 4'd1 || freq_ok2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL boundary_win2: got mv=%b cnt=%0d ok=%b, want 1 1 0",
                             meas_valid2, meas_count2, freq_ok2);
                end
            end
        end
        n_checks++;
        if (mv_cnt !== 2) begin
            n_fail++;
            $display("FAIL boundary_pulses: got %0d meas_valid pulses, want 2", mv_cnt);
        end
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_slow_clock();
        test_lost_clock();
        test_reset_midwindow();
        test_en_abort();
        test_saturate();
        test_window_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
